div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 start  in  1  request; sampled only in IDLE.
REQ-004 sign  in  1  1 = signed (DIV), 0 = unsigned (DIVU); latched with start.
REQ-005 a  in  32  dividend; latched with start.
REQ-006 b  in  32  divisor; latched with start.
REQ-007 busy  out  1  high while the operation is in progress (RUN or FIX).
REQ-008 done  out  1  one-cycle completion pulse.
REQ-009 q  out  32  quotient, registered.
REQ-010 r  out  32  remainder, registered.

Function
REQ-011 States: IDLE, RUN, FIX; IDLE->RUN on start, RUN->FIX after 32 iterations, FIX->IDLE always.
REQ-012 Edge E0 (IDLE, start=1): latch sign, |a|, |b| (magnitudes if sign=1 and operand negative, else raw), result signs; clear iteration counter and partial remainder.
REQ-013 Edges E1..E32: one restoring shift-subtract iteration per edge, one quotient bit per iteration, MSB first; 33-bit trial subtract.
REQ-014 Edge E33 (FIX): apply sign correction, load q/r, done=1, busy=0, state=IDLE; done and q/r visible in the cycle after E33.
REQ-015 done high for exactly one cycle; q/r hold until the next completion or reset.
REQ-016 busy=1 from the cycle after E0 through the cycle before done; busy and done never high together.
REQ-017 start while busy is ignored; operands are not resampled.
REQ-018 start in the done cycle is accepted (state is IDLE).
REQ-019 Signed: quotient truncated toward zero, negated iff a and b signs differ; remainder takes sign of a.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF: q=0x80000000, r=0; no trap or flag.
REQ-021 b=0: unsigned q=0xFFFFFFFF, r=a; signed q=0xFFFFFFFF if a>=0 else 0x00000001, r=a.
REQ-022 Inputs a/b/sign may change after E0 with no effect on the result.

Reset
REQ-023 rst=1 at any edge: state=IDLE, busy=0, done=0, q=0, r=0, counter=0.
REQ-024 Reset during RUN/FIX aborts the operation; no done pulse for it.
REQ-025 start is ignored on any edge where rst=1.

Configuration
REQ-026 Macro DIV_ZERO_FAST_EN: when defined, start with b=0 goes IDLE->FIX at E0, done visible after E1 (2-edge latency), results per REQ-021.
REQ-027 Without DIV_ZERO_FAST_EN: b=0 runs the full 32 iterations with latency per REQ-014; results are identical.

Structure
REQ-028 Package div_pkg holds the state enum, DIV_WIDTH=32, DIV_ITERS=32 and the counter width.
REQ-029 One combinational sub-module div_step performs a single shift-subtract iteration (partial remainder, divisor -> next remainder, quotient bit).
REQ-030 Sign correction and magnitude computation stay in div_unit.

Verification
REQ-031 sign=0, a=100, b=7 -> q=14, r=2; done in the cycle after E33; busy high for 33 cycles.
REQ-032 sign=1, a=0xFFFFFFF9 (-7), b=2 -> q=0xFFFFFFFD, r=0xFFFFFFFF; sign=0 with the same operands -> q=0x7FFFFFFC, r=1.
REQ-033 sign=1, a=0x80000000, b=0xFFFFFFFF -> q=0x80000000, r=0.
REQ-034 sign=0, a=0x12345678, b=0 -> q=0xFFFFFFFF, r=0x12345678; done after E1 with DIV_ZERO_FAST_EN, after E33 without it.
REQ-035 start pulsed again during iteration 5 with new operands -> first result unchanged, single done pulse.
REQ-036 rst at iteration 10 -> next cycle busy=0, done=0, q=r=0; no done pulse follows; a new start afterwards completes normally.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and sizing for the iterative 32-bit divider.
// DIV_ZERO_FAST_EN (see div_unit) shortens the divide-by-zero path.
package div_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_ITERS = 32;
   localparam int CNT_W     = $clog2(DIV_ITERS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX
   } state_e;

   function automatic logic [DIV_WIDTH-1:0] cond_neg(
      input logic [DIV_WIDTH-1:0] v,
      input logic                 neg
   );
      return neg ? -v : v;
   endfunction

endpackage

// File: rtl/div_if.sv
// Request/result bundle between a requester and the divider.
// Signal names follow the divider's external pin names.
interface div_if;
   import div_pkg::*;

   logic                 start;
   logic                 sign;
   logic [DIV_WIDTH-1:0] a;
   logic [DIV_WIDTH-1:0] b;
   logic                 busy;
   logic                 done;
   logic [DIV_WIDTH-1:0] q;
   logic [DIV_WIDTH-1:0] r;

   modport master (
      output start, sign, a, b,
      input  busy, done, q, r
   );

   modport slave (
      input  start, sign, a, b,
      output busy, done, q, r
   );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift in a dividend bit,
// trial-subtract the divisor, keep the difference if it did not borrow.
module div_step
   import div_pkg::*;
(
   input  logic [DIV_WIDTH-1:0] rem_i,
   input  logic                 dvd_msb_i,
   input  logic [DIV_WIDTH-1:0] dvs_i,
   output logic [DIV_WIDTH-1:0] rem_o,
   output logic                 qbit_o
);

   logic [DIV_WIDTH:0] shifted;
   logic [DIV_WIDTH:0] diff;
   logic [DIV_WIDTH:0] sel;
   logic               borrow;
   logic               unused_msb;

   assign shifted = {rem_i, dvd_msb_i};
   assign {borrow, diff} = {1'b0, shifted} - {2'b00, dvs_i};
   assign qbit_o = ~borrow;
   assign sel = borrow ? shifted : diff;

   // The kept value is always below the divisor, so its top bit is zero.
   assign rem_o = sel[DIV_WIDTH-1:0];
   assign unused_msb = sel[DIV_WIDTH];

endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned 32-bit divider, one quotient bit per cycle.
// Define DIV_ZERO_FAST_EN to skip the iterations when the divisor is zero.
module div_unit
   import div_pkg::*;
(
   input  logic clk,
   input  logic rst,
   div_if.slave bus
);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0] rem_q, rem_d;
   logic [DIV_WIDTH-1:0] dvd_q, dvd_d;
   logic [DIV_WIDTH-1:0] dvs_q, dvs_d;
   logic                 negq_q, negq_d;
   logic                 negr_q, negr_d;
   logic [DIV_WIDTH-1:0] q_q, q_d;
   logic [DIV_WIDTH-1:0] r_q, r_d;
   logic                 done_q, done_d;

   logic                 a_neg;
   logic                 b_neg;
   logic [DIV_WIDTH-1:0] step_rem;
   logic                 step_qbit;

   assign a_neg = bus.sign & bus.a[DIV_WIDTH-1];
   assign b_neg = bus.sign & bus.b[DIV_WIDTH-1];

   div_step u_step (
      .rem_i     (rem_q),
      .dvd_msb_i (dvd_q[DIV_WIDTH-1]),
      .dvs_i     (dvs_q),
      .rem_o     (step_rem),
      .qbit_o    (step_qbit)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      q_d     = q_q;
      r_d     = r_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               dvd_d   = cond_neg(bus.a, a_neg);
               dvs_d   = cond_neg(bus.b, b_neg);
               negq_d  = a_neg ^ b_neg;
               negr_d  = a_neg;
               cnt_d   = '0;
               rem_d   = '0;
               state_d = S_RUN;
`ifdef DIV_ZERO_FAST_EN
               // Same magnitudes the full loop would leave behind.
               if (bus.b == '0) begin
                  dvd_d   = '1;
                  rem_d   = cond_neg(bus.a, a_neg);
                  state_d = S_FIX;
               end
`endif
            end
         end
         S_RUN: begin
            // Quotient bits shift into the dividend register from the LSB.
            rem_d = step_rem;
            dvd_d = {dvd_q[DIV_WIDTH-2:0], step_qbit};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            q_d     = cond_neg(dvd_q, negq_q);
            r_d     = cond_neg(rem_q, negr_q);
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         q_q     <= '0;
         r_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         q_q     <= q_d;
         r_q     <= r_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = (state_q != S_IDLE);
   assign bus.done = done_q;
   assign bus.q    = q_q;
   assign bus.r    = r_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
// Zero-divisor latency expectation follows DIV_ZERO_FAST_EN.
module tb_div_unit;

   logic clk = 1'b0;
   logic rst;
   int   compares = 0;
   int   fails = 0;

`ifdef DIV_ZERO_FAST_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = 33;
`endif

   always #5 clk = ~clk;

   div_if bus ();

   div_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      compares++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic do_div(input string tag, input logic s,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input int elat);
      int n;
      int bc;
      bus.sign  = s;
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      bus.a     = ~a;
      bus.b     = b ^ 32'h0000_5a5a;
      bus.sign  = ~s;
      chk({tag, "_done_low"}, 32'(bus.done), 32'd0);
      n  = 0;
      bc = 0;
      while (!bus.done && n < 100) begin
         if (bus.busy) bc++;
         tick;
         n++;
      end
      chk({tag, "_lat"}, n, elat);
      chk({tag, "_busy_cyc"}, bc, elat);
      chk({tag, "_busy_done"}, 32'(bus.busy & bus.done), 32'd0);
      chk({tag, "_q"}, bus.q, eq);
      chk({tag, "_r"}, bus.r, er);
   endtask

   initial begin
      int pulses;
      int dl;
      logic [31:0] qv;
      logic [31:0] rv;

      rst       = 1'b1;
      bus.start = 1'b1;
      bus.sign  = 1'b0;
      bus.a     = 32'd100;
      bus.b     = 32'd7;
      tick;
      tick;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_q", bus.q, 32'd0);
      chk("rst_r", bus.r, 32'd0);
      bus.start = 1'b0;
      rst       = 1'b0;
      tick;

      do_div("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
      tick;
      chk("hold_done", 32'(bus.done), 32'd0);
      chk("hold_q", bus.q, 32'd14);
      chk("hold_r", bus.r, 32'd2);

      // back-to-back ops also start in the previous done cycle
      do_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
             32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
      do_div("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2,
             32'h7FFF_FFFC, 32'd1, 33);
      do_div("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
             32'h8000_0000, 32'd0, 33);
      do_div("s_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7,
             32'hFFFF_FFF2, 32'hFFFF_FFFE, 33);
      do_div("u_b0", 1'b0, 32'h1234_5678, 32'd0,
             32'hFFFF_FFFF, 32'h1234_5678, ZLAT);
      do_div("s_neg_b0", 1'b1, 32'hFFFF_FFF0, 32'd0,
             32'd1, 32'hFFFF_FFF0, ZLAT);
      do_div("s_pos_b0", 1'b1, 32'd5, 32'd0,
             32'hFFFF_FFFF, 32'd5, ZLAT);
      tick;

      bus.sign  = 1'b0;
      bus.a     = 32'd1000;
      bus.b     = 32'd10;
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      pulses = 0;
      dl     = 0;
      qv     = '0;
      rv     = '0;
      for (int e = 1; e <= 60; e++) begin
         bus.start = (e == 5);
         bus.a     = 32'd7;
         bus.b     = 32'd3;
         tick;
         if (bus.done) begin
            pulses++;
            if (pulses == 1) begin
               dl = e;
               qv = bus.q;
               rv = bus.r;
            end
         end
      end
      bus.start = 1'b0;
      chk("ign_pulses", pulses, 1);
      chk("ign_lat", dl, 33);
      chk("ign_q", qv, 32'd100);
      chk("ign_r", rv, 32'd0);

      bus.a     = 32'd50;
      bus.b     = 32'd3;
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      for (int i = 0; i < 9; i++) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_q", bus.q, 32'd0);
      chk("abort_r", bus.r, 32'd0);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         tick;
         if (bus.done) pulses++;
      end
      chk("abort_pulses", pulses, 0);

      do_div("post_rst", 1'b0, 32'd50, 32'd3, 32'd16, 32'd2, 33);
      tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compares, fails);
      $finish;
   end

endmodule
